// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin writeback arbiter feeding a single registered completion broadcast (CDB).
// Ports:
//    clk, rst_n                 clock, asynchronous active-low reset
//    s_valid / s_ready [NSRC]   per-source writeback handshake (source 0 = ALU, 1 = BRU)
//    s_uses_rd, s_epoch, s_rob_idx, s_prd_new, s_data, s_pc
//                               per-source payload, flattened with source i at slice i
//    cur_epoch, flush           front-end epoch and pipeline flush
//    cdb_valid / cdb_ready      registered completion broadcast handshake
//    cdb_uses_rd .. cdb_pc      registered broadcast payload
//    prf_we, prf_waddr, prf_wdata  physical register file write port
`ifndef ROB_W
`define ROB_W 6
`endif
`ifndef PHYS_W
`define PHYS_W 7
`endif

module wb_arbiter #(
   parameter int NSRC = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NSRC-1:0]           s_valid,
   output logic [NSRC-1:0]           s_ready,
   input  logic [NSRC-1:0]           s_uses_rd,
   input  logic [2*NSRC-1:0]         s_epoch,
   input  logic [`ROB_W*NSRC-1:0]    s_rob_idx,
   input  logic [`PHYS_W*NSRC-1:0]   s_prd_new,
   input  logic [32*NSRC-1:0]        s_data,
   input  logic [32*NSRC-1:0]        s_pc,
   input  logic [1:0]                cur_epoch,
   input  logic                      flush,
   output logic                      cdb_valid,
   input  logic                      cdb_ready,
   output logic                      cdb_uses_rd,
   output logic [1:0]                cdb_epoch,
   output logic [`ROB_W-1:0]         cdb_rob_idx,
   output logic [`PHYS_W-1:0]        cdb_prd_new,
   output logic [31:0]               cdb_data,
   output logic [31:0]               cdb_pc,
   output logic                      prf_we,
   output logic [`PHYS_W-1:0]        prf_waddr,
   output logic [31:0]               prf_wdata
);
   localparam int RW = NSRC > 1 ? $clog2(NSRC) : 1;
   localparam int PW = 1 + 2 + `ROB_W + `PHYS_W + 64;

   logic [NSRC-1:0] live;
   logic [PW-1:0]   pay [NSRC];
   logic [PW-1:0]   out_q;
   logic            out_vld_q;
   logic [RW-1:0]   rr_q, gnt_idx, cand;
   logic            gnt_any, out_can_accept, fire;

   assign out_can_accept = !out_vld_q || cdb_ready;
   assign fire = rst_n && gnt_any && out_can_accept && !flush;

   genvar i;
   generate
      for (i = 0; i < NSRC; i++) begin : g_src
         assign live[i] = s_valid[i] && (s_epoch[2*i +: 2] == cur_epoch);
         assign pay[i] = {s_uses_rd[i], s_epoch[2*i +: 2], s_rob_idx[`ROB_W*i +: `ROB_W],
                          s_prd_new[`PHYS_W*i +: `PHYS_W], s_data[32*i +: 32], s_pc[32*i +: 32]};
         // stale and flushed requests are accepted and dropped; live ones only on a real fire
         assign s_ready[i] = rst_n && s_valid[i] && (flush || !live[i] || (fire && gnt_idx == RW'(i)));
      end
   endgenerate

   // scan from the farthest candidate back to rr_q so the closest live source wins
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = rr_q;
      cand    = '0;
      for (int k = NSRC - 1; k >= 0; k--) begin
         cand = RW'((int'(rr_q) + k) % NSRC);
         if (live[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld_q <= 1'b0;
         out_q     <= '0;
         rr_q      <= '0;
      end else if (flush) begin
         out_vld_q <= 1'b0;
      end else if (fire) begin
         out_vld_q <= 1'b1;
         out_q     <= pay[gnt_idx];
         rr_q      <= (gnt_idx == RW'(NSRC - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (cdb_ready) begin
         out_vld_q <= 1'b0;
      end
   end

   assign cdb_valid = out_vld_q;
   assign {cdb_uses_rd, cdb_epoch, cdb_rob_idx, cdb_prd_new, cdb_data, cdb_pc} = out_q;
   assign prf_we    = out_vld_q && cdb_ready && cdb_uses_rd;
   assign prf_waddr = cdb_prd_new;
   assign prf_wdata = cdb_data;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and randomized checks of wb_arbiter against a scoreboard of expected broadcasts.
`ifndef ROB_W
`define ROB_W 6
`endif
`ifndef PHYS_W
`define PHYS_W 7
`endif

module tb_wb_arbiter;
   localparam int RB = `ROB_W;
   localparam int PH = `PHYS_W;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [1:0]    s_valid = '0;
   logic [1:0]    s_ready;
   logic [1:0]    s_uses_rd = '0;
   logic [3:0]    s_epoch = '0;
   logic [2*RB-1:0] s_rob_idx = '0;
   logic [2*PH-1:0] s_prd_new = '0;
   logic [63:0]   s_data = '0;
   logic [63:0]   s_pc = '0;
   logic [1:0]    cur_epoch = 2'd1;
   logic          flush = 1'b0;
   logic          cdb_valid;
   logic          cdb_ready = 1'b0;
   logic          cdb_uses_rd;
   logic [1:0]    cdb_epoch;
   logic [RB-1:0] cdb_rob_idx;
   logic [PH-1:0] cdb_prd_new;
   logic [31:0]   cdb_data;
   logic [31:0]   cdb_pc;
   logic          prf_we;
   logic [PH-1:0] prf_waddr;
   logic [31:0]   prf_wdata;

   wb_arbiter #(.NSRC(2)) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
      .s_uses_rd(s_uses_rd), .s_epoch(s_epoch), .s_rob_idx(s_rob_idx),
      .s_prd_new(s_prd_new), .s_data(s_data), .s_pc(s_pc),
      .cur_epoch(cur_epoch), .flush(flush), .cdb_valid(cdb_valid), .cdb_ready(cdb_ready),
      .cdb_uses_rd(cdb_uses_rd), .cdb_epoch(cdb_epoch), .cdb_rob_idx(cdb_rob_idx),
      .cdb_prd_new(cdb_prd_new), .cdb_data(cdb_data), .cdb_pc(cdb_pc),
      .prf_we(prf_we), .prf_waddr(prf_waddr), .prf_wdata(prf_wdata)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          u;
      logic [RB-1:0] rob;
      logic [PH-1:0] prd;
      logic [31:0]   data;
      logic [31:0]   pc;
   } pay_t;

   pay_t       sb[$];
   int         n_vec = 0;
   int         n_err = 0;
   int         tag[2];
   logic [1:0] ep[2];
   logic       m_vld = 1'b0;
   int         m_rr = 0;
   int         rrb;

   // transaction t of source i; pc bit 12 identifies the source
   function automatic pay_t gen(input int i, input int t);
      pay_t p;
      p.u    = (t % 3) != 1;
      p.rob  = RB'(t);
      p.prd  = PH'(t + 4);
      p.data = 32'h1234 + 32'(i) * 32'h10_0000 + 32'(t - 5) * 32'h100;
      p.pc   = 32'h8000_0000 + 32'(i) * 32'h1000 + 32'(t) * 4;
      return p;
   endfunction

   task automatic apply();
      pay_t p;
      for (int i = 0; i < 2; i++) begin
         p = gen(i, tag[i]);
         s_uses_rd[i]          = p.u;
         s_epoch[2*i +: 2]     = ep[i];
         s_rob_idx[i*RB +: RB] = p.rob;
         s_prd_new[i*PH +: PH] = p.prd;
         s_data[32*i +: 32]    = p.data;
         s_pc[32*i +: 32]      = p.pc;
      end
   endtask

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // one clock of stimulus: check comb/registered outputs against the model, then advance
   task automatic cycle();
      logic [1:0] lv, er;
      logic       can;
      int         w;
      pay_t       p;
      apply();
      #1;
      for (int i = 0; i < 2; i++) lv[i] = s_valid[i] && (ep[i] == cur_epoch);
      can = !m_vld || cdb_ready;
      w = lv[m_rr] ? m_rr : (lv[1-m_rr] ? 1 - m_rr : -1);
      for (int i = 0; i < 2; i++) er[i] = s_valid[i] && (flush || !lv[i] || (i == w && can));
      chk("s_ready", 64'(s_ready), 64'(er));
      chk("cdb_valid", 64'(cdb_valid), 64'(m_vld));
      if (m_vld) begin
         n_vec++;
         assert (sb.size() != 0) else begin
            n_err++;
            $error("FAIL sb_entry observed=cdb_valid expected=no_entry");
         end
         if (sb.size() != 0) begin
            p = sb[0];
            chk("cdb_rob_idx", 64'(cdb_rob_idx), 64'(p.rob));
            chk("cdb_prd_new", 64'(cdb_prd_new), 64'(p.prd));
            chk("cdb_data", 64'(cdb_data), 64'(p.data));
            chk("cdb_pc", 64'(cdb_pc), 64'(p.pc));
            chk("cdb_uses_rd", 64'(cdb_uses_rd), 64'(p.u));
            chk("prf_we", 64'(prf_we), 64'(cdb_ready && p.u));
            chk("prf_waddr", 64'(prf_waddr), 64'(p.prd));
            chk("prf_wdata", 64'(prf_wdata), 64'(p.data));
            if (cdb_ready) void'(sb.pop_front());
         end
      end else chk("prf_we_idle", 64'(prf_we), 64'd0);
      if (flush) begin
         sb.delete();
         m_vld = 1'b0;
      end else if (w >= 0 && can) begin
         sb.push_back(gen(w, tag[w]));
         m_vld = 1'b1;
         m_rr  = 1 - w;
      end else if (cdb_ready) m_vld = 1'b0;
      for (int i = 0; i < 2; i++) if (er[i]) tag[i]++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      tag[0] = 5; tag[1] = 5; ep[0] = 2'd1; ep[1] = 2'd1;
      // reset state with live requests present
      s_valid = 2'b11; cdb_ready = 1'b1;
      apply();
      #2;
      chk("rst_s_ready", 64'(s_ready), 64'd0);
      chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
      chk("rst_prf_we", 64'(prf_we), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1; s_valid = 2'b00;
      cycle();
      // contention: 0,1,0,1 with cdb_valid continuously high
      s_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         cycle();
         chk("cont_valid", 64'(cdb_valid), 64'd1);
         chk("cont_src", 64'(cdb_pc[12]), 64'(k % 2));
      end
      s_valid = 2'b00;
      cycle();
      cycle();
      // single ALU writeback with fixed payload
      tag[0] = 5; s_valid = 2'b01;
      cycle();
      s_valid = 2'b00;
      chk("single_valid", 64'(cdb_valid), 64'd1);
      chk("single_rob", 64'(cdb_rob_idx), 64'd5);
      chk("single_prf_we", 64'(prf_we), 64'd1);
      chk("single_waddr", 64'(prf_waddr), 64'd9);
      chk("single_wdata", 64'(prf_wdata), 64'h1234);
      cycle();
      // backpressure: held entry keeps ALU stalled, then retire+load together
      s_valid = 2'b01;
      cycle();
      cdb_ready = 1'b0;
      cycle();
      cycle();
      chk("bp_s_ready", 64'(s_ready), 64'd0);
      cdb_ready = 1'b1;
      cycle();
      chk("bp_reload", 64'(cdb_valid), 64'd1);
      s_valid = 2'b00;
      cycle();
      cycle();
      // stale BRU: dropped immediately, no broadcast, pointer unchanged
      rrb = m_rr;
      ep[1] = 2'd0; s_valid = 2'b10;
      cycle();
      chk("stale_no_cdb", 64'(cdb_valid), 64'd0);
      ep[1] = 2'd1; s_valid = 2'b11;
      cycle();
      chk("stale_rr_hold", 64'(cdb_pc[12]), 64'(rrb));
      s_valid = 2'b00;
      cycle();
      // flush with held entry and both sources requesting
      s_valid = 2'b01; cdb_ready = 1'b0;
      cycle();
      s_valid = 2'b11; flush = 1'b1;
      cycle();
      chk("flush_clear", 64'(cdb_valid), 64'd0);
      // flush coinciding with a cdb handshake still writes the PRF
      flush = 1'b0; s_valid = 2'b01; cdb_ready = 1'b1;
      cycle();
      s_valid = 2'b00; flush = 1'b1;
      cycle();
      flush = 1'b0;
      cycle();
      // randomized traffic against the model
      for (int k = 0; k < 60; k++) begin
         s_valid   = 2'($urandom);
         ep[0]     = ($urandom % 4 == 0) ? cur_epoch ^ 2'd1 : cur_epoch;
         ep[1]     = ($urandom % 4 == 0) ? cur_epoch ^ 2'd2 : cur_epoch;
         cdb_ready = ($urandom % 4) != 0;
         flush     = ($urandom % 12) == 0;
         cycle();
      end
      flush = 1'b0; ep[0] = cur_epoch; ep[1] = cur_epoch;
      // reset mid-transfer discards the entry; source 0 wins first afterwards
      s_valid = 2'b01; cdb_ready = 1'b0;
      cycle();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(cdb_valid), 64'd0);
      chk("mid_rst_prf_we", 64'(prf_we), 64'd0);
      chk("mid_rst_s_ready", 64'(s_ready), 64'd0);
      sb.delete(); m_vld = 1'b0; m_rr = 0;
      @(posedge clk); #1;
      rst_n = 1'b1; s_valid = 2'b11; cdb_ready = 1'b1;
      cycle();
      chk("post_rst_valid", 64'(cdb_valid), 64'd1);
      chk("post_rst_src0", 64'(cdb_pc[12]), 64'd0);
      s_valid = 2'b00;
      cycle();
      cycle();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: NSRC, 2, number of writeback sources; source 0 = ALU, source 1 = BRU.
REQ-002 Parameter widths ROB_W and PHYS_W SHALL be taken from defines.svh and are not module parameters.
REQ-003 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: s_valid  input  NSRC  per-source writeback valid.
REQ-006 Port: s_ready  output  NSRC  per-source writeback ready.
REQ-007 Port: s_uses_rd, s_epoch, s_rob_idx, s_prd_new, s_data, s_pc  input  NSRC x {1, 2, ROB_W, PHYS_W, 32, 32}  per-source writeback payload.
REQ-008 Port: cur_epoch  input  2  current front-end epoch.
REQ-009 Port: flush  input  1  pipeline flush.
REQ-010 Port: cdb_valid  output  1  completion broadcast valid.
REQ-011 Port: cdb_ready  input  1  ROB accept.
REQ-012 Port: cdb_uses_rd, cdb_epoch, cdb_rob_idx, cdb_prd_new, cdb_data, cdb_pc  output  {1, 2, ROB_W, PHYS_W, 32, 32}  registered payload.
REQ-013 Port: prf_we  output  1; prf_waddr  output  PHYS_W; prf_wdata  output  32  physical register file write.

Function
REQ-014 The block SHALL hold a 1-entry output register (out_vld_q plus payload) driving all cdb_* outputs directly.
REQ-015 out_can_accept SHALL equal !out_vld_q || cdb_ready, giving a 1-deep skid with no bubble under continuous cdb_ready.
REQ-016 A source is live when s_valid[i]=1 and s_epoch[i]==cur_epoch; it is stale when s_valid[i]=1 and s_epoch[i]!=cur_epoch.
REQ-017 A stale source SHALL see s_ready[i]=1 in the same cycle, SHALL be dropped, and SHALL NOT take a grant.
REQ-018 A round-robin pointer rr_q SHALL choose among live sources: source rr_q wins if live, otherwise the other live source wins.
REQ-019 After a grant to source g fires, rr_q SHALL update to (g+1) mod NSRC; otherwise rr_q SHALL hold.
REQ-020 For a live source, s_ready[i] SHALL be 1 only when i is granted and out_can_accept=1; each cycle SHALL have at most one live fire.
REQ-021 On a live fire, the output register SHALL load the winner's payload and set out_vld_q=1, so latency from source handshake to cdb_valid is 1 cycle.
REQ-022 If cdb_ready=1 with out_vld_q=1 and no live fire occurs, out_vld_q SHALL clear.
REQ-023 prf_we SHALL equal out_vld_q && cdb_ready && cdb_uses_rd.
REQ-024 prf_waddr SHALL equal cdb_prd_new, and prf_wdata SHALL equal cdb_data.
REQ-025 When flush=1:
 - out_vld_q SHALL clear next cycle;
 - no grant SHALL occur and rr_q SHALL hold;
 - every s_ready[i] with s_valid[i]=1 SHALL be 1, dropping all requests.
REQ-026 Flush SHALL take priority over cdb_ready dequeue and live fires in the same cycle.
REQ-027 A cdb handshake in the flush cycle (cdb_valid && cdb_ready) still counts, and prf_we follows REQ-023.
REQ-028 cdb_valid SHALL NOT depend combinationally on s_valid.
REQ-029 s_ready MAY depend combinationally on cdb_ready, s_valid, s_epoch, cur_epoch and flush.
REQ-030 While a source's s_valid=1 and s_ready=0, its payload is held stable by the source; the arbiter SHALL NOT assume this payload was latched.

Reset
REQ-031 While rst_n=0, the block SHALL hold out_vld_q=0, all output payload registers=0, and rr_q=0, taking effect asynchronously.
REQ-032 While rst_n=0, s_ready, cdb_valid and prf_we SHALL read 0.
REQ-033 A reset asserted mid-transfer SHALL discard the held entry; the first grant after reset SHALL favour source 0.

Verification
REQ-034 Single source: ALU valid, epoch=cur=1, rob=5, prd=9, data=0x1234, uses_rd=1, cdb_ready=1 -> next cycle cdb_valid=1, rob_idx=5, prf_we=1, prf_waddr=9, prf_wdata=0x1234.
REQ-035 Contention: both sources live for 4 cycles, cdb_ready=1 -> grants in order 0,1,0,1, with cdb_valid continuously 1 from cycle 1.
REQ-036 Backpressure: cdb_ready=0 with entry held, ALU valid -> s_ready=0 and payload unchanged; raising cdb_ready -> held entry retires and ALU loads in the same cycle.
REQ-037 Stale epoch: BRU valid with epoch=0, cur_epoch=1 -> s_ready[1]=1 the same cycle, nothing appears on cdb, and rr_q is unchanged.
REQ-038 Flush: entry held with ALU and BRU both valid, flush=1 -> both s_ready=1, next cycle cdb_valid=0.
REQ-039 Reset asserted with cdb_valid=1 -> cdb_valid=0 immediately; after release, both sources live -> source 0 granted first.
